// File: rtl/apb_demux_n.sv
// APB 1:N demultiplexer. It decodes one upstream APB request onto one of NUM_SLV downstream slaves.
// Define APB_DEMUX_TIMEOUT_EN to build the ACCESS-phase timeout; otherwise ACCESS waits indefinitely.
module apb_demux_n #(
  parameter int NUM_SLV  = 4,
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32,
  // Slave 0 sits in the LSBs: slave0=0x1004_0000, slave1=0x1000_0000, slave2=0x1000_1000, slave3=0x1000_2000.
  parameter logic [NUM_SLV*P_ADDR_W-1:0] SLV_BASE =
    {32'h1000_2000, 32'h1000_1000, 32'h1000_0000, 32'h1004_0000},
  parameter logic [NUM_SLV*P_ADDR_W-1:0] SLV_MASK = {4{32'hFFFF_F000}},
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic [P_ADDR_W-1:0]          paddr,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [P_DATA_W-1:0]          pwdata,
  input  logic [P_DATA_W/8-1:0]        pwstrb,
  output logic                         pready,
  output logic [P_DATA_W-1:0]          prdata,
  output logic                         pslverr,
  output logic [NUM_SLV-1:0]           psel_o,
  output logic [P_ADDR_W-1:0]          paddr_o,
  output logic                         penable_o,
  output logic                         pwrite_o,
  output logic [P_DATA_W-1:0]          pwdata_o,
  output logic [P_DATA_W/8-1:0]        pwstrb_o,
  input  logic [NUM_SLV-1:0]           pready_i,
  input  logic [NUM_SLV*P_DATA_W-1:0]  prdata_i,
  input  logic [NUM_SLV-1:0]           pslverr_i,
  output logic                         timeout_o
);

  localparam int P_STRB_W = P_DATA_W / 8;
  localparam int IDX_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("apb_demux_n: NUM_SLV or TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_dec_idx;
  logic                w_dec_hit;
  logic                w_accept;
  logic [P_ADDR_W-1:0] r_paddr;
  logic                r_pwrite;
  logic [P_DATA_W-1:0] r_pwdata;
  logic [P_STRB_W-1:0] r_pwstrb;
  logic [P_DATA_W-1:0] r_prdata;
  logic                r_pslverr;
  logic                w_sel_ready;
  logic                w_sel_err;
  logic [P_DATA_W-1:0] w_sel_rdata;
  logic                w_tmo_hit;

  assign w_accept = psel && !penable;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_idx = '0;
    // Scan downward so that the lowest matching index is the one kept.
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((paddr & SLV_MASK[i*P_ADDR_W +: P_ADDR_W]) == SLV_BASE[i*P_ADDR_W +: P_ADDR_W]) begin
        w_dec_hit = 1'b1;
        w_dec_idx = IDX_W'(i);
      end
    end
  end

  assign w_sel_ready = pready_i[r_idx];
  assign w_sel_err   = pslverr_i[r_idx];
  assign w_sel_rdata = prdata_i[r_idx*P_DATA_W +: P_DATA_W];

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values whatever the process order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    psel_o      = '0;
    penable_o   = 1'b0;
    pready      = 1'b0;
    prdata      = '0;
    pslverr     = 1'b0;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_dec_hit ? S_SETUP : S_RESP;
      S_SETUP: begin
        psel_o[r_idx] = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        psel_o[r_idx] = 1'b1;
        penable_o     = 1'b1;
        if (w_sel_ready || w_tmo_hit) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        pready      = 1'b1;
        prdata      = r_prdata;
        pslverr     = r_pslverr;
        w_state_nxt = S_IDLE;
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_idx     <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pwstrb  <= '0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_dec_hit) begin
            r_idx    <= w_dec_idx;
            r_paddr  <= paddr;
            r_pwrite <= pwrite;
            r_pwdata <= pwdata;
            r_pwstrb <= pwstrb;
          end else if (w_accept) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (w_sel_ready) begin
            r_prdata  <= r_pwrite ? '0 : w_sel_rdata;
            r_pslverr <= w_sel_err;
          end else if (w_tmo_hit) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign paddr_o  = r_paddr;
  assign pwrite_o = r_pwrite;
  assign pwdata_o = r_pwdata;
  assign pwstrb_o = r_pwstrb;

`ifdef APB_DEMUX_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout;

  assign w_tmo_hit = (r_state == S_ACCESS) && !w_sel_ready &&
                     (r_wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_tmo_hit;
      if (r_state == S_IDLE && w_accept && w_dec_hit) r_wait_cnt <= '0;
      else if (r_state == S_ACCESS && !w_sel_ready)   r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_demux_n.sv
// Directed self-checking bench for apb_demux_n, using the default address map and 4 slaves.
// The timeout scenario is built only when APB_DEMUX_TIMEOUT_EN is defined (TIMEOUT_CYC=16).
module tb_apb_demux_n;
  logic         pclk = 1'b0;
  logic         presetn;
  logic [31:0]  paddr;
  logic         psel, penable, pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pwstrb;
  logic         pready;
  logic [31:0]  prdata;
  logic         pslverr;
  logic [3:0]   psel_o;
  logic [31:0]  paddr_o;
  logic         penable_o, pwrite_o;
  logic [31:0]  pwdata_o;
  logic [3:0]   pwstrb_o;
  logic [3:0]   pready_i;
  logic [127:0] prdata_i;
  logic [3:0]   pslverr_i;
  logic         timeout_o;

  int n_vec = 0;
  int n_err = 0;

  // Observations of the most recent transfer
  int          got_lat, got_acc;
  logic [31:0] got_rdata, got_paddr, got_wdata;
  logic [3:0]  got_sel, got_strb;
  logic        got_err, got_tmo, got_wr, got_stable, got_quiet, got_idle0;

  always #5 pclk = ~pclk;

  apb_demux_n #(.NUM_SLV(4), .P_ADDR_W(32), .P_DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .psel_o(psel_o), .paddr_o(paddr_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pwstrb_o(pwstrb_o), .pready_i(pready_i),
    .prdata_i(prdata_i), .pslverr_i(pslverr_i), .timeout_o(timeout_o)
  );

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog");
  end

  // Upstream master plus a simple downstream slave. It only drives the DUT and records observations.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int slv, input int waits,
                      input logic [31:0] rdata, input logic err, input bit drop_psel);
    int acc;
    @(negedge pclk);
    got_idle0 = (psel_o === 4'b0) && (pready === 1'b0) && (penable_o === 1'b0);
    paddr = addr; pwrite = wr; pwdata = wdata; pwstrb = strb; psel = 1'b1; penable = 1'b0;
    pready_i = '0; pslverr_i = '0;
    for (int s = 0; s < 4; s++) prdata_i[s*32 +: 32] = 32'hDEAD_0000 | 32'(s);
    if (slv >= 0) prdata_i[slv*32 +: 32] = rdata;
    acc = 0; got_lat = -1; got_stable = 1'b1; got_quiet = 1'b1;
    got_sel = '0; got_rdata = '0; got_err = 1'b0; got_tmo = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge pclk);
      if (cyc == 1) begin
        got_sel = psel_o; got_paddr = paddr_o; got_wdata = pwdata_o;
        got_wr = pwrite_o; got_strb = pwstrb_o;
        if (drop_psel) psel = 1'b0;
        else           penable = 1'b1;
      end else if (psel_o !== 4'b0 && (psel_o !== got_sel || paddr_o !== got_paddr ||
                   pwdata_o !== got_wdata || pwrite_o !== got_wr || pwstrb_o !== got_strb)) begin
        got_stable = 1'b0;
      end
      if (pready === 1'b1) begin
        got_lat = cyc; got_rdata = prdata; got_err = pslverr; got_tmo = timeout_o;
        break;
      end
      if (prdata !== 32'h0 || pslverr !== 1'b0 || timeout_o !== 1'b0) got_quiet = 1'b0;
      if (penable_o === 1'b1) begin
        acc++;
        if (slv >= 0) begin
          pready_i[slv]  = (acc > waits);
          pslverr_i[slv] = (acc > waits) ? err : 1'b0;
        end
      end
    end
    got_acc = acc;
    psel = 1'b0; penable = 1'b0; pready_i = '0; pslverr_i = '0;
  endtask

  task automatic test_reset;
    #2;
    n_vec++; if (pready !== 1'b0)      begin n_err++; $display("FAIL rst_pready: got %b want 0", pready); end
    n_vec++; if (psel_o !== 4'b0)      begin n_err++; $display("FAIL rst_psel_o: got %b want 0000", psel_o); end
    n_vec++; if (penable_o !== 1'b0)   begin n_err++; $display("FAIL rst_penable_o: got %b want 0", penable_o); end
    n_vec++; if (prdata !== 32'h0)     begin n_err++; $display("FAIL rst_prdata: got %h want 0", prdata); end
    n_vec++; if (pslverr !== 1'b0)     begin n_err++; $display("FAIL rst_pslverr: got %b want 0", pslverr); end
    n_vec++; if (timeout_o !== 1'b0)   begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
    n_vec++; if (paddr_o !== 32'h0 || pwdata_o !== 32'h0 || pwstrb_o !== 4'h0 || pwrite_o !== 1'b0)
      begin n_err++; $display("FAIL rst_captured: got addr %h data %h strb %h wr %b want zeros", paddr_o, pwdata_o, pwstrb_o, pwrite_o); end
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
  endtask

  task automatic test_write;
    xfer(32'h1000_0004, 1'b1, 32'hA5A5_0001, 4'hF, 1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    n_vec++; if (got_sel !== 4'b0010)        begin n_err++; $display("FAIL wr_psel_o: got %b want 0010", got_sel); end
    n_vec++; if (got_wdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL wr_pwdata_o: got %h want a5a50001", got_wdata); end
    n_vec++; if (got_paddr !== 32'h1000_0004 || got_wr !== 1'b1 || got_strb !== 4'hF)
      begin n_err++; $display("FAIL wr_fields: got addr %h wr %b strb %h want 10000004 1 f", got_paddr, got_wr, got_strb); end
    n_vec++; if (got_lat !== 3)              begin n_err++; $display("FAIL wr_latency: got %0d want 3", got_lat); end
    n_vec++; if (got_err !== 1'b0)           begin n_err++; $display("FAIL wr_pslverr: got %b want 0", got_err); end
    n_vec++; if (got_rdata !== 32'h0)        begin n_err++; $display("FAIL wr_prdata: got %h want 0", got_rdata); end
    n_vec++; if (got_quiet !== 1'b1)         begin n_err++; $display("FAIL wr_quiet: got %b want 1", got_quiet); end
  endtask

  task automatic test_read_wait;
    xfer(32'h1000_2010, 1'b0, 32'h0, 4'h0, 3, 5, 32'h1234_5678, 1'b0, 1'b0);
    n_vec++; if (got_sel !== 4'b1000)         begin n_err++; $display("FAIL rd_psel_o: got %b want 1000", got_sel); end
    n_vec++; if (got_lat !== 8)               begin n_err++; $display("FAIL rd_latency: got %0d want 8", got_lat); end
    n_vec++; if (got_acc !== 6)               begin n_err++; $display("FAIL rd_access_cycles: got %0d want 6", got_acc); end
    n_vec++; if (got_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL rd_prdata: got %h want 12345678", got_rdata); end
    n_vec++; if (got_err !== 1'b0)            begin n_err++; $display("FAIL rd_pslverr: got %b want 0", got_err); end
    n_vec++; if (got_stable !== 1'b1)         begin n_err++; $display("FAIL rd_stable: got %b want 1", got_stable); end
    n_vec++; if (got_quiet !== 1'b1)          begin n_err++; $display("FAIL rd_quiet: got %b want 1", got_quiet); end
  endtask

  task automatic test_unmapped;
    xfer(32'h2000_0000, 1'b0, 32'h0, 4'h0, -1, 0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (got_lat !== 1)        begin n_err++; $display("FAIL um_latency: got %0d want 1", got_lat); end
    n_vec++; if (got_sel !== 4'b0 || got_acc !== 0)
      begin n_err++; $display("FAIL um_no_psel: got sel %b access %0d want 0000 0", got_sel, got_acc); end
    n_vec++; if (got_err !== 1'b1)     begin n_err++; $display("FAIL um_pslverr: got %b want 1", got_err); end
    n_vec++; if (got_rdata !== 32'h0)  begin n_err++; $display("FAIL um_prdata: got %h want 0", got_rdata); end
  endtask

  task automatic test_slverr;
    xfer(32'h1004_0100, 1'b0, 32'h0, 4'h0, 0, 1, 32'hCAFE_F00D, 1'b1, 1'b0);
    n_vec++; if (got_sel !== 4'b0001)          begin n_err++; $display("FAIL se_psel_o: got %b want 0001", got_sel); end
    n_vec++; if (got_lat !== 4)                begin n_err++; $display("FAIL se_latency: got %0d want 4", got_lat); end
    n_vec++; if (got_err !== 1'b1)             begin n_err++; $display("FAIL se_pslverr: got %b want 1", got_err); end
    n_vec++; if (got_rdata !== 32'hCAFE_F00D)  begin n_err++; $display("FAIL se_prdata: got %h want cafef00d", got_rdata); end
  endtask

  task automatic test_strobe;
    xfer(32'h1000_1FFC, 1'b1, 32'h0102_0304, 4'b0101, 2, 0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (got_sel !== 4'b0100 || got_strb !== 4'b0101 || got_paddr !== 32'h1000_1FFC)
      begin n_err++; $display("FAIL st_fields: got sel %b strb %b addr %h want 0100 0101 10001ffc", got_sel, got_strb, got_paddr); end
    n_vec++; if (got_lat !== 3) begin n_err++; $display("FAIL st_latency: got %0d want 3", got_lat); end
  endtask

  task automatic test_drop_psel;
    xfer(32'h1000_0FF0, 1'b0, 32'h0, 4'h0, 1, 2, 32'h0BAD_BEEF, 1'b0, 1'b1);
    n_vec++; if (got_lat !== 5)               begin n_err++; $display("FAIL dp_latency: got %0d want 5", got_lat); end
    n_vec++; if (got_rdata !== 32'h0BAD_BEEF) begin n_err++; $display("FAIL dp_prdata: got %h want 0badbeef", got_rdata); end
  endtask

  task automatic test_back_to_back;
    xfer(32'h1000_2000, 1'b1, 32'h5555_AAAA, 4'hC, 3, 0, 32'h0, 1'b0, 1'b0);
    n_vec++; if (got_lat !== 3 || got_sel !== 4'b1000)
      begin n_err++; $display("FAIL b2b_first: got lat %0d sel %b want 3 1000", got_lat, got_sel); end
    xfer(32'h1004_0FFC, 1'b0, 32'h0, 4'h0, 0, 0, 32'h7777_1111, 1'b0, 1'b0);
    n_vec++; if (got_idle0 !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap: got %b want 1", got_idle0); end
    n_vec++; if (got_lat !== 3 || got_sel !== 4'b0001 || got_rdata !== 32'h7777_1111)
      begin n_err++; $display("FAIL b2b_second: got lat %0d sel %b data %h want 3 0001 77771111", got_lat, got_sel, got_rdata); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge pclk);
    paddr = 32'h1000_1008; pwrite = 1'b1; pwdata = 32'h1; pwstrb = 4'hF; psel = 1'b1; penable = 1'b0;
    pready_i = '0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    n_vec++; if (psel_o !== 4'b0100 || penable_o !== 1'b1)
      begin n_err++; $display("FAIL rm_access: got sel %b en %b want 0100 1", psel_o, penable_o); end
    #2 presetn = 1'b0;
    #1;
    n_vec++; if (psel_o !== 4'b0 || penable_o !== 1'b0 || pready !== 1'b0 || paddr_o !== 32'h0)
      begin n_err++; $display("FAIL rm_async_drop: got sel %b en %b rdy %b addr %h want zeros", psel_o, penable_o, pready, paddr_o); end
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (pready !== 1'b0 || psel_o !== 4'b0) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rm_no_resp: got activity %b want 0", seen); end
    xfer(32'h1000_0000, 1'b0, 32'h0, 4'h0, 1, 0, 32'h4242_4242, 1'b0, 1'b0);
    n_vec++; if (got_lat !== 3 || got_rdata !== 32'h4242_4242)
      begin n_err++; $display("FAIL rm_recover: got lat %0d data %h want 3 42424242", got_lat, got_rdata); end
  endtask

`ifdef APB_DEMUX_TIMEOUT_EN
  task automatic test_timeout;
    xfer(32'h1000_1000, 1'b0, 32'h0, 4'h0, 2, 1000, 32'h9999_9999, 1'b0, 1'b0);
    n_vec++; if (got_acc !== 16)      begin n_err++; $display("FAIL to_access_cycles: got %0d want 16", got_acc); end
    n_vec++; if (got_lat !== 18)      begin n_err++; $display("FAIL to_latency: got %0d want 18", got_lat); end
    n_vec++; if (got_tmo !== 1'b1)    begin n_err++; $display("FAIL to_pulse: got %b want 1", got_tmo); end
    n_vec++; if (got_err !== 1'b1 || got_rdata !== 32'h0)
      begin n_err++; $display("FAIL to_resp: got err %b data %h want 1 0", got_err, got_rdata); end
    n_vec++; if (got_quiet !== 1'b1)  begin n_err++; $display("FAIL to_quiet: got %b want 1", got_quiet); end
    @(negedge pclk);
    n_vec++; if (timeout_o !== 1'b0)  begin n_err++; $display("FAIL to_pulse_width: got %b want 0", timeout_o); end
    xfer(32'h1004_0020, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0F0F_0F0F, 1'b0, 1'b0);
    n_vec++; if (got_lat !== 3 || got_err !== 1'b0 || got_rdata !== 32'h0F0F_0F0F || got_tmo !== 1'b0)
      begin n_err++; $display("FAIL to_followup: got lat %0d err %b data %h tmo %b want 3 0 0f0f0f0f 0", got_lat, got_err, got_rdata, got_tmo); end
  endtask
`endif

  initial begin
    presetn = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pwstrb = '0; pready_i = '0; prdata_i = '0; pslverr_i = '0;
    #2 presetn = 1'b0;
    test_reset;
    test_write;
    test_read_wait;
    test_unmapped;
    test_slverr;
    test_strobe;
    test_drop_psel;
    test_back_to_back;
    test_reset_mid;
`ifdef APB_DEMUX_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
